hud_scoreboard: RTL and testbench

//  Parametrised HUD block: holds per-player BCD score counters and half-heart HP registers,
//  and renders score digits and heart glyphs as a registered per-pixel overlay for the colour mapper.

---
 rtl/hud_pkg.sv | 21 ++
 rtl/hud_score_counter.sv | 46 ++++
 rtl/hud_scoreboard.sv | 154 +++++++++++++++
 tb/tb_hud_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared types, glyph codes and the single-digit BCD adder used by the HUD.
package hud_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [3:0] GLYPH_HEART_FULL  = 4'd10;
  localparam logic [3:0] GLYPH_HEART_HALF  = 4'd11;
  localparam logic [3:0] GLYPH_HEART_EMPTY = 4'd12;

  localparam int CHAR_W_DEF = 30;
  localparam int CHAR_H_DEF = 45;

  // One BCD digit plus carry-in; returns {carry_out, sum_digit}.
  function automatic logic [4:0] bcd_add_digit(input bcd_t a, input bcd_t b, input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return s;
  endfunction

endpackage

// File: rtl/hud_score_counter.sv
// Per-player BCD score register with single-cycle ripple add and saturation at all nines.
module hud_score_counter
  import hud_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  add_valid_i,
  input  bcd_t                  add_pts_i,
  output logic [N_DIGITS*4-1:0] score_o
);

  logic [N_DIGITS*4-1:0] score_q, score_d, sum;
  logic [N_DIGITS:0]     carry;
  logic [4:0]            r;
  bcd_t                  pts;

  // Ripple the clamped points through all digits; a carry out of the top digit saturates.
  always_comb begin
    pts   = (add_pts_i > 4'd9) ? 4'd9 : add_pts_i;
    carry = '0;
    sum   = '0;
    r     = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      r                = bcd_add_digit(score_q[d*4 +: 4], (d == 0) ? pts : 4'd0, carry[d]);
      sum[d*4 +: 4]    = r[3:0];
      carry[d+1]       = r[4];
    end
    score_d = score_q;
    if (clr_i)
      score_d = '0;
    else if (add_valid_i)
      score_d = carry[N_DIGITS] ? {N_DIGITS{4'd9}} : sum;
  end

  // Score register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/hud_scoreboard.sv
// HUD overlay: per-player scores and half-heart HP with damage blink,
// rendered as a registered per-pixel glyph lookup for the sprite ROM.
module hud_scoreboard
  import hud_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int N_DIGITS     = 4,
  parameter int N_HEARTS     = 4,
  parameter int CHAR_W       = CHAR_W_DEF,
  parameter int CHAR_H       = CHAR_H_DEF,
  parameter int HUD_X0       = 510,
  parameter int SCORE_Y0     = 90,
  parameter int HEART_DY     = 60,
  parameter int PLAYER_DY    = 240,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_tick,
  input  logic                            game_rst,
  input  logic [N_PLAYERS-1:0]            add_valid,
  input  logic [N_PLAYERS*4-1:0]          add_pts,
  input  logic [N_PLAYERS-1:0]            dmg,
  input  logic [N_PLAYERS-1:0]            heal,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  output logic [N_PLAYERS*4-1:0]          hp_out,
  output logic [N_PLAYERS-1:0]            dead,
  output logic [N_PLAYERS*N_DIGITS*4-1:0] score_out,
  output logic                            is_char,
  output logic [3:0]                      char_idx,
  output logic [18:0]                     char_read_address
);

  localparam int             HP_MAX     = 2 * N_HEARTS;
  localparam int             BW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [3:0]     HP_MAX_V   = 4'(HP_MAX);
  localparam logic [BW-1:0]  BLINK_LOAD = BW'(BLINK_FRAMES);

  logic [N_PLAYERS-1:0][3:0]    hp_q, hp_d;
  logic [N_PLAYERS-1:0][BW-1:0] blink_q, blink_d;

  logic        is_char_q, is_char_d;
  logic [3:0]  idx_q, idx_d;
  logic [18:0] addr_q, addr_d;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_score
    hud_score_counter #(.N_DIGITS(N_DIGITS)) u_cnt (
      .clk         (Clk),
      .rst         (Reset),
      .clr_i       (game_rst),
      .add_valid_i (add_valid[p]),
      .add_pts_i   (add_pts[p*4 +: 4]),
      .score_o     (score_out[p*N_DIGITS*4 +: N_DIGITS*4])
    );
  end

  // HP and blink next state; an accepted hit reloads blink, game_rst overrides everything.
  always_comb begin
    hp_d    = hp_q;
    blink_d = blink_q;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (frame_tick && blink_q[p] != '0)
        blink_d[p] = blink_q[p] - BW'(1);
      if (dmg[p] && !heal[p] && hp_q[p] != 4'd0) begin
        hp_d[p]    = hp_q[p] - 4'd1;
        blink_d[p] = BLINK_LOAD;
      end else if (heal[p] && !dmg[p] && hp_q[p] < HP_MAX_V) begin
        hp_d[p] = hp_q[p] + 4'd1;
      end
      if (game_rst) begin
        hp_d[p]    = HP_MAX_V;
        blink_d[p] = '0;
      end
    end
  end

  // HP and blink registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hp_q    <= {N_PLAYERS{HP_MAX_V}};
      blink_q <= '0;
    end else begin
      hp_q    <= hp_d;
      blink_q <= blink_d;
    end
  end

  assign hp_out = hp_q;

  // Dead flag per player.
  always_comb begin
    dead = '0;
    for (int p = 0; p < N_PLAYERS; p++) dead[p] = (hp_q[p] == 4'd0);
  end

  logic [31:0] px, py, bx, by;
  logic        hide;

  // First-hit search in priority order: player, then score before hearts, then index.
  always_comb begin
    is_char_d = 1'b0;
    idx_d     = '0;
    addr_d    = '0;
    px        = {22'd0, DrawX};
    py        = {22'd0, DrawY};
    bx        = '0;
    by        = '0;
    hide      = 1'b0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      for (int d = 0; d < N_DIGITS; d++) begin
        bx = 32'(HUD_X0 + (N_DIGITS - 1 - d) * CHAR_W);
        by = 32'(SCORE_Y0 + p * PLAYER_DY);
        if (!is_char_d && px >= bx && py >= by &&
            (px - bx) < 32'(CHAR_W) && (py - by) < 32'(CHAR_H)) begin
          is_char_d = 1'b1;
          idx_d     = score_out[(p*N_DIGITS + d)*4 +: 4];
          addr_d    = 19'((px - bx) + (py - by) * 32'(CHAR_W));
        end
      end
      hide = (blink_q[p] != '0) && blink_q[p][1];
      for (int k = 0; k < N_HEARTS; k++) begin
        bx = 32'(HUD_X0 + k * CHAR_W);
        by = 32'(SCORE_Y0 + HEART_DY + p * PLAYER_DY);
        if (!hide && !is_char_d && px >= bx && py >= by &&
            (px - bx) < 32'(CHAR_W) && (py - by) < 32'(CHAR_H)) begin
          is_char_d = 1'b1;
          if ({28'd0, hp_q[p]} >= 32'(2*k + 2))      idx_d = GLYPH_HEART_FULL;
          else if ({28'd0, hp_q[p]} == 32'(2*k + 1)) idx_d = GLYPH_HEART_HALF;
          else                                       idx_d = GLYPH_HEART_EMPTY;
          addr_d    = 19'((px - bx) + (py - by) * 32'(CHAR_W));
        end
      end
    end
  end

  // Single pixel pipeline stage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_char_q <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
    end else begin
      is_char_q <= is_char_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
    end
  end

  assign is_char           = is_char_q;
  assign char_idx          = idx_q;
  assign char_read_address = addr_q;

endmodule

// File: tb/tb_hud_scoreboard.sv
// Scoreboard-driven bench for hud_scoreboard (default parameters).
module tb_hud_scoreboard;

  logic        Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, game_rst = 1'b0;
  logic [1:0]  add_valid = '0, dmg = '0, heal = '0;
  logic [7:0]  add_pts = '0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [7:0]  hp_out;
  logic [1:0]  dead;
  logic [31:0] score_out;
  logic        is_char;
  logic [3:0]  char_idx;
  logic [18:0] char_read_address;
  logic [31:0] pix_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sbq[$];
  logic [31:0] e;

  hud_scoreboard dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_rst(game_rst),
    .add_valid(add_valid), .add_pts(add_pts), .dmg(dmg), .heal(heal),
    .DrawX(DrawX), .DrawY(DrawY), .hp_out(hp_out), .dead(dead),
    .score_out(score_out), .is_char(is_char), .char_idx(char_idx),
    .char_read_address(char_read_address)
  );

  assign pix_o = {8'd0, is_char, char_idx, char_read_address};

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(int c, int i, int a);
    return {8'd0, 1'(c), 4'(i), 19'(a)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_pix(int x, int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  task automatic add_score(int p, int pts);
    add_valid[p]      = 1'b1;
    add_pts[p*4 +: 4] = 4'(pts);
    tick();
    add_valid = '0;
    add_pts   = '0;
  endtask

  task automatic pulse_dmg(int p);
    dmg[p] = 1'b1;
    tick();
    dmg = '0;
  endtask

  task automatic pulse_heal(int p);
    heal[p] = 1'b1;
    tick();
    heal = '0;
  endtask

  task automatic frames(int n);
    frame_tick = 1'b1;
    repeat (n) tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_pix(510, 90);
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++; if (score_out !== 32'h0) begin n_bad++; $display("FAIL reset_score: got %h want %h", score_out, 32'h0); end
    n_cmp++; if (hp_out !== 8'h88)    begin n_bad++; $display("FAIL reset_hp: got %h want %h", hp_out, 8'h88); end
    n_cmp++; if (dead !== 2'b00)      begin n_bad++; $display("FAIL reset_dead: got %b want 00", dead); end
    n_cmp++; if (pix_o !== 32'h0)     begin n_bad++; $display("FAIL reset_pix: got %h want 0", pix_o); end
    Reset = 1'b0;
    set_pix(0, 0);
    sbq.push_back(pk(0, 0, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL reset_next_pix: got %h want %h", pix_o, e); end
  endtask

  task automatic test_score();
    for (int i = 0; i < 110; i++) add_score(0, 9);
    add_score(0, 8);
    sbq.push_back(32'h0998);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[15:0]} !== e) begin n_bad++; $display("FAIL score_0998: got %h want %h", score_out[15:0], e[15:0]); end
    add_score(0, 5);
    sbq.push_back(32'h1003);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[15:0]} !== e) begin n_bad++; $display("FAIL score_carry: got %h want %h", score_out[15:0], e[15:0]); end
    n_cmp++; if (score_out[31:16] !== 16'h0000) begin n_bad++; $display("FAIL score_p1_idle: got %h want 0000", score_out[31:16]); end
    for (int i = 0; i < 999; i++) add_score(0, 9);
    add_score(0, 3);
    sbq.push_back(32'h9997);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[15:0]} !== e) begin n_bad++; $display("FAIL score_9997: got %h want %h", score_out[15:0], e[15:0]); end
    add_score(0, 9);
    sbq.push_back(32'h9999);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[15:0]} !== e) begin n_bad++; $display("FAIL score_sat: got %h want %h", score_out[15:0], e[15:0]); end
    add_score(0, 1);
    sbq.push_back(32'h9999);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[15:0]} !== e) begin n_bad++; $display("FAIL score_sat_hold: got %h want %h", score_out[15:0], e[15:0]); end
    add_score(1, 15);
    sbq.push_back(32'h0009);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[31:16]} !== e) begin n_bad++; $display("FAIL score_clamp_pts: got %h want %h", score_out[31:16], e[15:0]); end
    add_pts = 8'h70;
    tick();
    add_pts = '0;
    sbq.push_back(32'h0009);
    e = sbq.pop_front();
    n_cmp++; if ({16'd0, score_out[31:16]} !== e) begin n_bad++; $display("FAIL score_no_valid: got %h want %h", score_out[31:16], e[15:0]); end
    add_valid = 2'b11;
    add_pts   = 8'h91;
    tick();
    add_valid = '0;
    add_pts   = '0;
    sbq.push_back(32'h00189999);
    e = sbq.pop_front();
    n_cmp++; if (score_out !== e) begin n_bad++; $display("FAIL score_both: got %h want %h", score_out, e); end
  endtask

  task automatic test_hp();
    for (int i = 1; i <= 8; i++) begin
      pulse_dmg(1);
      sbq.push_back(32'(8 - i));
      e = sbq.pop_front();
      n_cmp++; if ({28'd0, hp_out[7:4]} !== e) begin n_bad++; $display("FAIL hp_dmg_%0d: got %0d want %0d", i, hp_out[7:4], e); end
    end
    n_cmp++; if (dead !== 2'b10) begin n_bad++; $display("FAIL dead_p1: got %b want 10", dead); end
    frames(14);
    pulse_dmg(1);
    n_cmp++; if (hp_out[7:4] !== 4'd0) begin n_bad++; $display("FAIL hp_floor: got %0d want 0", hp_out[7:4]); end
    set_pix(510, 390);
    sbq.push_back(pk(0, 0, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL no_reload_at_zero: got %h want %h", pix_o, e); end
    frames(2);
    sbq.push_back(pk(1, 12, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL empty_heart: got %h want %h", pix_o, e); end
    pulse_heal(1);
    n_cmp++; if (hp_out[7:4] !== 4'd1 || dead !== 2'b00) begin n_bad++; $display("FAIL heal_revive: got hp %0d dead %b want 1 00", hp_out[7:4], dead); end
    sbq.push_back(pk(1, 11, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL half_heart: got %h want %h", pix_o, e); end
    for (int i = 0; i < 8; i++) pulse_heal(1);
    n_cmp++; if (hp_out[7:4] !== 4'd8) begin n_bad++; $display("FAIL heal_sat: got %0d want 8", hp_out[7:4]); end
  endtask

  task automatic test_blink();
    int  bm;
    logic hid;
    pulse_dmg(0);
    pulse_dmg(0);
    frames(16);
    set_pix(510, 150);
    pulse_dmg(0);
    n_cmp++; if (hp_out[3:0] !== 4'd5) begin n_bad++; $display("FAIL blink_hp5: got %0d want 5", hp_out[3:0]); end
    sbq.push_back(pk(1, 10, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL blink_cnt16: got %h want %h", pix_o, e); end
    frames(1);
    sbq.push_back(pk(0, 0, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL blink_cnt15: got %h want %h", pix_o, e); end
    set_pix(600, 90);
    sbq.push_back(pk(1, 9, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL blink_digit_vis: got %h want %h", pix_o, e); end
    set_pix(510, 390);
    sbq.push_back(pk(1, 10, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL blink_other_player: got %h want %h", pix_o, e); end
    set_pix(510, 150);
    bm = 15;
    for (int i = 0; i < 16; i++) begin
      frames(1);
      if (bm > 0) bm--;
      hid = (bm != 0) && ((bm / 2) % 2 == 1);
      sbq.push_back(hid ? pk(0, 0, 0) : pk(1, 10, 0));
      tick();
      e = sbq.pop_front();
      n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL blink_cnt%0d: got %h want %h", bm, pix_o, e); end
    end
  endtask

  task automatic test_heart_row();
    int          tx[15] = '{510, 540, 570, 600, 539, 540, 540, 630, 509, 600, 629, 510, 570, 600, 630};
    int          ty[15] = '{150, 150, 150, 150, 150, 194, 195, 150, 150, 90, 134, 330, 330, 374, 330};
    logic [31:0] te[15];
    te = '{pk(1, 10, 0), pk(1, 10, 0), pk(1, 11, 0), pk(1, 12, 0), pk(1, 10, 29),
           pk(1, 10, 1320), pk(0, 0, 0), pk(0, 0, 0), pk(0, 0, 0), pk(1, 9, 0),
           pk(1, 9, 1349), pk(1, 0, 0), pk(1, 1, 0), pk(1, 8, 1320), pk(0, 0, 0)};
    for (int i = 0; i < 15; i++) begin
      set_pix(tx[i], ty[i]);
      sbq.push_back(te[i]);
      tick();
      e = sbq.pop_front();
      n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL pix_%0d_%0d: got %h want %h", tx[i], ty[i], pix_o, e); end
    end
  endtask

  task automatic test_reload();
    pulse_dmg(0);
    frames(2);
    set_pix(510, 150);
    sbq.push_back(pk(0, 0, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL reload_pre: got %h want %h", pix_o, e); end
    pulse_dmg(0);
    sbq.push_back(pk(1, 10, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL reload_post: got %h want %h", pix_o, e); end
    n_cmp++; if (hp_out[3:0] !== 4'd3) begin n_bad++; $display("FAIL reload_hp: got %0d want 3", hp_out[3:0]); end
  endtask

  task automatic test_dmg_heal_same();
    dmg  = 2'b11;
    heal = 2'b11;
    tick();
    dmg  = '0;
    heal = '0;
    n_cmp++; if (hp_out !== 8'h83) begin n_bad++; $display("FAIL dmg_heal_same: got %h want 83", hp_out); end
  endtask

  task automatic test_game_rst();
    frames(2);
    set_pix(510, 150);
    game_rst  = 1'b1;
    add_valid = 2'b11;
    add_pts   = 8'h55;
    dmg       = 2'b01;
    tick();
    game_rst  = 1'b0;
    add_valid = '0;
    add_pts   = '0;
    dmg       = '0;
    n_cmp++; if (score_out !== 32'h0) begin n_bad++; $display("FAIL game_rst_score: got %h want 0", score_out); end
    n_cmp++; if (hp_out !== 8'h88 || dead !== 2'b00) begin n_bad++; $display("FAIL game_rst_hp: got %h %b want 88 00", hp_out, dead); end
    sbq.push_back(pk(1, 10, 0));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL game_rst_blink: got %h want %h", pix_o, e); end
  endtask

  task automatic test_reset_midline();
    add_score(0, 3);
    set_pix(602, 91);
    sbq.push_back(pk(1, 3, 32));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL midline_pre: got %h want %h", pix_o, e); end
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (pix_o !== 32'h0) begin n_bad++; $display("FAIL midline_pix: got %h want 0", pix_o); end
    n_cmp++; if (score_out !== 32'h0 || hp_out !== 8'h88) begin n_bad++; $display("FAIL midline_state: got %h %h want 0 88", score_out, hp_out); end
    #2 Reset = 1'b0;
    sbq.push_back(pk(1, 0, 32));
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pix_o !== e) begin n_bad++; $display("FAIL midline_post: got %h want %h", pix_o, e); end
  endtask

  initial begin
    test_reset();
    test_score();
    test_hp();
    test_blink();
    test_heart_row();
    test_reload();
    test_dmg_heal_same();
    test_game_rst();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
